// File: rtl/mpr121_array_scanner.sv
// mpr121_array_scanner: brings up NUM_DEVICES MPR121 sensors over a shared I2C
// transaction port, then sweeps healthy devices into an atomically updated touch vector.
module mpr121_array_scanner #(
   parameter int unsigned NUM_DEVICES    = 3,
   parameter logic [6:0]  BASE_ADDR      = 7'h5A,
   parameter logic [7:0]  TOUCH_THRESH   = 8'h0F,
   parameter logic [7:0]  RELEASE_THRESH = 8'h0A,
   parameter logic [7:0]  ECR_RUN        = 8'h0C,
   parameter int unsigned MAX_RETRIES    = 3,
   parameter int unsigned TIMEOUT_CYCLES = 200000
) (
   input  logic                      clk_in,
   input  logic                      rst_in,
   output logic                      i2c_start_out,
   output logic [6:0]                i2c_addr_out,
   output logic                      i2c_rw_out,
   output logic [7:0]                i2c_cmd_out,
   output logic [7:0]                i2c_wdata_out,
   input  logic [7:0]                i2c_rdata_in,
   input  logic                      i2c_ack_in,
   input  logic                      i2c_done_in,
   output logic [12*NUM_DEVICES-1:0] touch_status_out,
   output logic [NUM_DEVICES-1:0]    device_ok_out,
   output logic                      init_done_out,
   output logic                      valid_out,
   output logic                      error_out,
   output logic [15:0]               sweep_count_out
);
   typedef enum logic [3:0] {
      IDLE, INIT_STOP, INIT_THRESH, INIT_RUN, CHK_CDT, CHK_ECR, SCAN_LO, SCAN_HI, WAIT, CMP, HALT
   } state_t;

   state_t state_q, state_d, op_q, op_d, go_op;
   logic [2:0] dev_q, dev_d, go_dev;
   logic [4:0] thr_q, thr_d, go_thr;
   logic [7:0] retry_q, retry_d, lo_q, lo_d, rdat_q, rdat_d;
   logic [31:0] tmo_q, tmo_d;
   logic [NUM_DEVICES-1:0] ok_q, ok_d;
   logic [12*NUM_DEVICES-1:0] shadow_q, shadow_d, touch_q, touch_d;
   logic [15:0] sweep_q, sweep_d;
   logic init_done_q, init_done_d, valid_q, valid_d, err_q, err_d;
   logic start_q, start_d, rw_q, rw_d;
   logic [6:0] addr_q, addr_d;
   logic [7:0] cmd_q, cmd_d, wdata_q, wdata_d;
   logic go, tx_ok, tx_bad;
   logic [3:0] sel;

   // Returns {found, index} of the lowest set mask bit at or above 'from'.
   function automatic logic [3:0] first_ok(input logic [NUM_DEVICES-1:0] mask, input int from);
      logic [3:0] r;
      r = 4'd0;
      for (int i = int'(NUM_DEVICES) - 1; i >= 0; i--)
         if (mask[i] && i >= from) r = {1'b1, 3'(i)};
      return r;
   endfunction

   always_comb begin
      state_d = state_q;
      op_d = op_q;
      dev_d = dev_q;
      thr_d = thr_q;
      retry_d = retry_q;
      tmo_d = tmo_q;
      lo_d = lo_q;
      rdat_d = rdat_q;
      ok_d = ok_q;
      shadow_d = shadow_q;
      touch_d = touch_q;
      sweep_d = sweep_q;
      init_done_d = init_done_q;
      err_d = err_q;
      valid_d = 1'b0;
      start_d = 1'b0;
      addr_d = addr_q;
      rw_d = rw_q;
      cmd_d = cmd_q;
      wdata_d = wdata_q;
      go = 1'b0;
      go_op = INIT_STOP;
      go_dev = dev_q;
      go_thr = 5'd0;
      tx_ok = 1'b0;
      tx_bad = 1'b0;
      sel = 4'd0;
      if (state_q == IDLE) begin
         go = 1'b1;
         go_dev = 3'd0;
      end else if (state_q == WAIT) begin
         if (i2c_done_in && i2c_ack_in && (op_q == CHK_CDT || op_q == CHK_ECR)) begin
            state_d = CMP;
            rdat_d = i2c_rdata_in;
         end else if (i2c_done_in) begin
            tx_ok = i2c_ack_in;
            tx_bad = !i2c_ack_in;
         end else if (tmo_q == TIMEOUT_CYCLES) tx_bad = 1'b1;
         else tmo_d = tmo_q + 32'd1;
      end else if (state_q == CMP) begin
         tx_ok = rdat_q == (op_q == CHK_CDT ? 8'h24 : ECR_RUN);
         tx_bad = !tx_ok;
      end
      if ((tx_ok || tx_bad) && op_q != SCAN_LO && op_q != SCAN_HI) begin
         if (tx_ok && op_q != CHK_ECR) begin
            go = 1'b1;
            if (op_q == INIT_STOP) go_op = INIT_THRESH;
            else if (op_q == INIT_THRESH) go_op = thr_q == 5'd23 ? INIT_RUN : INIT_THRESH;
            else if (op_q == INIT_RUN) go_op = CHK_CDT;
            else go_op = CHK_ECR;
            go_thr = (op_q == INIT_THRESH && thr_q != 5'd23) ? thr_q + 5'd1 : 5'd0;
         end else if (tx_bad && retry_q != 8'(MAX_RETRIES - 1)) begin
            go = 1'b1;
            retry_d = retry_q + 8'd1;
         end else begin
            retry_d = 8'd0;
            err_d = err_q | tx_bad;
            for (int i = 0; i < int'(NUM_DEVICES); i++)
               if (i == int'(dev_q)) ok_d[i] = tx_ok;
            if (32'(dev_q) == NUM_DEVICES - 1) begin
               init_done_d = 1'b1;
               sel = first_ok(ok_d, 0);
               go = sel[3];
               go_op = SCAN_LO;
               go_dev = sel[2:0];
               if (!sel[3]) state_d = HALT;
            end else begin
               go = 1'b1;
               go_dev = dev_q + 3'd1;
            end
         end
      end else if (tx_ok || tx_bad) begin
         go = 1'b1;
         if (tx_ok && op_q == SCAN_LO) begin
            lo_d = i2c_rdata_in;
            go_op = SCAN_HI;
         end else begin
            // A failed scan read keeps this device's previous shadow bits.
            for (int i = 0; i < int'(NUM_DEVICES); i++)
               if (tx_ok && i == int'(dev_q)) shadow_d[12*i +: 12] = {i2c_rdata_in[3:0], lo_q};
            go_op = SCAN_LO;
            sel = first_ok(ok_q, int'(dev_q) + 1);
            if (!sel[3]) begin
               sel = first_ok(ok_q, 0);
               valid_d = 1'b1;
               touch_d = shadow_d;
               sweep_d = sweep_q + 16'd1;
            end
            go_dev = sel[2:0];
         end
      end
      if (go) begin
         start_d = 1'b1;
         state_d = WAIT;
         op_d = go_op;
         dev_d = go_dev;
         thr_d = go_thr;
         tmo_d = 32'd0;
         addr_d = BASE_ADDR + 7'(go_dev);
         rw_d = go_op inside {CHK_CDT, CHK_ECR, SCAN_LO, SCAN_HI};
         cmd_d = go_op == INIT_THRESH ? 8'h41 + 8'(go_thr) : go_op == CHK_CDT ? 8'h5D :
                 go_op == SCAN_LO ? 8'h00 : go_op == SCAN_HI ? 8'h01 : 8'h5E;
         wdata_d = go_op == INIT_RUN ? ECR_RUN :
                   go_op == INIT_THRESH ? (go_thr[0] ? RELEASE_THRESH : TOUCH_THRESH) : 8'h00;
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q <= IDLE;
         op_q <= IDLE;
         dev_q <= 3'd0;
         thr_q <= 5'd0;
         retry_q <= 8'd0;
         tmo_q <= 32'd0;
         lo_q <= 8'd0;
         rdat_q <= 8'd0;
         ok_q <= '0;
         shadow_q <= '0;
         touch_q <= '0;
         sweep_q <= 16'd0;
         init_done_q <= 1'b0;
         valid_q <= 1'b0;
         err_q <= 1'b0;
         start_q <= 1'b0;
         addr_q <= BASE_ADDR;
         rw_q <= 1'b0;
         cmd_q <= 8'd0;
         wdata_q <= 8'd0;
      end else begin
         state_q <= state_d;
         op_q <= op_d;
         dev_q <= dev_d;
         thr_q <= thr_d;
         retry_q <= retry_d;
         tmo_q <= tmo_d;
         lo_q <= lo_d;
         rdat_q <= rdat_d;
         ok_q <= ok_d;
         shadow_q <= shadow_d;
         touch_q <= touch_d;
         sweep_q <= sweep_d;
         init_done_q <= init_done_d;
         valid_q <= valid_d;
         err_q <= err_d;
         start_q <= start_d;
         addr_q <= addr_d;
         rw_q <= rw_d;
         cmd_q <= cmd_d;
         wdata_q <= wdata_d;
      end
   end

   assign i2c_start_out = start_q;
   assign i2c_addr_out = addr_q;
   assign i2c_rw_out = rw_q;
   assign i2c_cmd_out = cmd_q;
   assign i2c_wdata_out = wdata_q;
   assign touch_status_out = touch_q;
   assign device_ok_out = ok_q;
   assign init_done_out = init_done_q;
   assign valid_out = valid_q;
   assign error_out = err_q;
   assign sweep_count_out = sweep_q;
endmodule

// File: tb/tb_mpr121_array_scanner.sv
// tb_mpr121_array_scanner: bus model plus scoreboard of expected I2C requests and sweep results.
module tb_mpr121_array_scanner;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start, rw, ack, done, valid, init_done, err;
   logic [6:0] addr;
   logic [7:0] cmd, wdata, rdata;
   logic [35:0] touch;
   logic [2:0] ok;
   logic [15:0] sweep;

   always #5 clk = ~clk;

   mpr121_array_scanner #(.NUM_DEVICES(3), .TIMEOUT_CYCLES(50)) dut (
      .clk_in(clk), .rst_in(rst), .i2c_start_out(start), .i2c_addr_out(addr), .i2c_rw_out(rw),
      .i2c_cmd_out(cmd), .i2c_wdata_out(wdata), .i2c_rdata_in(rdata), .i2c_ack_in(ack),
      .i2c_done_in(done), .touch_status_out(touch), .device_ok_out(ok), .init_done_out(init_done),
      .valid_out(valid), .error_out(err), .sweep_count_out(sweep)
   );

   int checks = 0, errors = 0, cyc = 0, rel_cyc = 0, tx_idx = 0;
   logic [23:0] txq[$];
   logic [51:0] vq[$];
   int start_cyc[$];
   logic [2:0] nack_mask = 3'b000;
   bit cdt_bad0 = 1'b0, tmo_mode = 1'b0;
   int nth = 0;
   logic [7:0] lo_v[3] = '{8'h12, 8'hA5, 8'h34};
   logic [7:0] hi_v[3] = '{8'h04, 8'hF3, 8'hFE};
   localparam logic [35:0] FULL = 36'hE343A5412;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [23:0] tx(input int dev, input logic r, input logic [7:0] c, input logic [7:0] w);
      return {7'(7'h5A + dev), r, c, w};
   endfunction

   function automatic logic [23:0] init_tx(input int dev, input int k);
      if (k == 0) return tx(dev, 1'b0, 8'h5E, 8'h00);
      if (k <= 24) return tx(dev, 1'b0, 8'(8'h40 + k), (k % 2 == 1) ? 8'h0F : 8'h0A);
      if (k == 25) return tx(dev, 1'b0, 8'h5E, 8'h0C);
      return tx(dev, 1'b1, k == 26 ? 8'h5D : 8'h5E, 8'h00);
   endfunction

   task automatic push_init(input int dev, input int n);
      for (int k = 0; k < n; k++) txq.push_back(init_tx(dev, k));
   endtask

   task automatic push_scan(input int dev);
      txq.push_back(tx(dev, 1'b1, 8'h00, 8'h00));
      txq.push_back(tx(dev, 1'b1, 8'h01, 8'h00));
   endtask

   task automatic wait_drain(input string name, input int budget);
      int n = 0;
      while ((txq.size() != 0 || vq.size() != 0) && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk(name, 64'(txq.size() + vq.size()), 64'd0);
   endtask

   task automatic rst_checks(input string tag);
      chk({tag, "_ctl"}, {59'd0, start, rw, valid, init_done, err}, 64'd0);
      chk({tag, "_addr"}, 64'(addr), 64'h5A);
      chk({tag, "_cmd_wdata"}, 64'({cmd, wdata}), 64'd0);
      chk({tag, "_touch"}, 64'(touch), 64'd0);
      chk({tag, "_ok"}, 64'(ok), 64'd0);
      chk({tag, "_sweep"}, 64'(sweep), 64'd0);
   endtask

   task automatic enter_reset();
      @(negedge clk);
      rst = 1'b1;
      repeat (5) @(negedge clk);
      txq.delete();
      vq.delete();
      nth = 0;
   endtask

   task automatic release_reset();
      start_cyc.delete();
      rst = 1'b0;
      rel_cyc = cyc;
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // I2C controller model: done arrives d cycles after the start it answers.
   initial begin
      logic pend;
      int cnt, d, dv;
      logic [6:0] ra;
      logic [7:0] rc;
      pend = 1'b0;
      cnt = 0;
      d = 2;
      ra = 7'h5A;
      rc = 8'h00;
      done = 1'b0;
      ack = 1'b0;
      rdata = 8'h00;
      forever begin
         @(negedge clk);
         done = 1'b0;
         if (pend) begin
            cnt++;
            if (cnt == d) begin
               pend = 1'b0;
               dv = int'(ra) - 32'h5A;
               done = 1'b1;
               ack = !nack_mask[dv];
               rdata = rc == 8'h5D ? ((cdt_bad0 && dv == 0) ? 8'h00 : 8'h24) : rc == 8'h5E ? 8'h0C :
                       rc == 8'h00 ? lo_v[dv] : rc == 8'h01 ? hi_v[dv] : 8'h00;
               if (rc == 8'h5D && dv == 0) cdt_bad0 = 1'b0;
            end
         end
         if (start && !rst) begin
            ra = addr;
            rc = cmd;
            cnt = 0;
            d = (tmo_mode && nth == 1) ? 50 : 2;
            pend = !(tmo_mode && nth == 0);
            nth++;
         end
      end
   end

   // Monitor: pops expected requests and sweep results as the DUT presents them.
   initial begin
      logic [35:0] last_touch;
      logic [51:0] e;
      last_touch = 'x;
      forever begin
         @(posedge clk);
         #2;
         if (start) begin
            start_cyc.push_back(cyc);
            if (txq.size() != 0) begin
               chk($sformatf("txn%0d", tx_idx), 64'({addr, rw, cmd, wdata}), 64'(txq.pop_front()));
               tx_idx++;
            end
         end
         if (valid && vq.size() != 0) begin
            e = vq.pop_front();
            chk("sweep_touch", 64'(touch), 64'(e[51:16]));
            chk("sweep_count", 64'(sweep), 64'(e[15:0]));
         end
         if (touch !== last_touch && !rst) chk("touch_update_with_valid", 64'(valid), 64'd1);
         last_touch = touch;
      end
   end

   initial begin
      int n;
      repeat (3) @(negedge clk);
      rst_checks("reset");
      // Healthy bus
      for (int dv = 0; dv < 3; dv++) push_init(dv, 28);
      for (int dv = 0; dv < 3; dv++) push_scan(dv);
      for (int s = 1; s <= 3; s++) vq.push_back({FULL, 16'(s)});
      release_reset();
      wait_drain("healthy_drain", 3000);
      chk("healthy_first_start_latency", 64'(start_cyc.size() != 0 ? start_cyc[0] - rel_cyc : -1), 64'd1);
      chk("healthy_ok", 64'(ok), 64'b111);
      chk("healthy_done_err", 64'({init_done, err}), 64'b10);
      // Reset during a device 2 scan read
      n = 0;
      while (!(start && addr == 7'h5C && rw) && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("wait_dev2_read", 64'({start, addr, rw}), 64'({1'b1, 7'h5C, 1'b1}));
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst_checks("midscan_reset");
      repeat (4) @(negedge clk);
      txq.delete();
      vq.delete();
      push_init(0, 2);
      release_reset();
      wait_drain("restart_drain", 100);
      // Device 1 NACKs everything
      enter_reset();
      nack_mask = 3'b010;
      push_init(0, 28);
      for (int r = 0; r < 3; r++) push_init(1, 1);
      push_init(2, 28);
      push_scan(0);
      push_scan(2);
      vq.push_back({36'hE34000412, 16'd1});
      release_reset();
      wait_drain("dead_drain", 3000);
      chk("dead_ok", 64'(ok), 64'b101);
      chk("dead_done_err", 64'({init_done, err}), 64'b11);
      // First device-0 CDT readback mismatches
      enter_reset();
      nack_mask = 3'b000;
      cdt_bad0 = 1'b1;
      push_init(0, 27);
      for (int dv = 0; dv < 3; dv++) push_init(dv, 28);
      vq.push_back({FULL, 16'd1});
      release_reset();
      wait_drain("mismatch_drain", 3000);
      chk("mismatch_ok", 64'(ok), 64'b111);
      chk("mismatch_err", 64'(err), 64'd0);
      // Timeout: first request never completes, retry completes exactly at the limit
      enter_reset();
      tmo_mode = 1'b1;
      push_init(0, 1);
      push_init(0, 2);
      release_reset();
      wait_drain("timeout_drain", 500);
      chk("timeout_retry_gap", 64'(start_cyc.size() >= 3 ? start_cyc[1] - start_cyc[0] : -1), 64'd51);
      chk("done_at_limit_gap", 64'(start_cyc.size() >= 3 ? start_cyc[2] - start_cyc[1] : -1), 64'd51);
      n = 0;
      while (!init_done && n < 2000) begin
         @(negedge clk);
         n++;
      end
      chk("timeout_ok", 64'({init_done, err, ok}), 64'b10111);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
